// File: rtl/bg_model_pkg.sv
// Shared constants for the background-model frame store.
//   DATA_W        pixel / background sample width
//   ADDR_W        frame-store address width
//   FRAME_W/H     active frame geometry
//   FRAME_PIXELS  active pixels per frame (must be <= 2**ADDR_W)
//   RD_LAT        BRAM read latency in cycles (>= 1)
package bg_model_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned ADDR_W       = 17;
  localparam int unsigned FRAME_W      = 320;
  localparam int unsigned FRAME_H      = 240;
  localparam int unsigned FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int unsigned RD_LAT       = 2;

endpackage

// File: rtl/bg_delay_line.sv
// Synchronous-reset shift register, DEPTH stages of W bits.
//   clk   rising-edge clock
//   rst   synchronous active-high reset, clears every stage
//   din   stage-0 input, shifted every clock
//   dout  output of the last stage (DEPTH cycles after din)
module bg_delay_line #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/bg_model_reader.sv
// Read side of the background-model frame store. Issues one BRAM read per live
// pixel (same cycle, combinational address) and re-times the pixel stream by the
// BRAM latency so every output pixel is paired with its background sample and the
// address it came from (used by the update stage for write-back).
//   clk, rst              clock, synchronous active-high reset
//   in_de/vsync/pixel     input pixel stream (vsync = frame start level)
//   mem_rd_en/mem_addr    BRAM read request
//   mem_rdata             BRAM read data, RD_LAT cycles after the request
//   out_de/vsync/pixel    input stream delayed RD_LAT cycles
//   out_bg                background sample for out_pixel (mem_rdata, unregistered)
//   out_addr              address out_bg was read from
//   frame_err             sticky: a frame ran past FRAME_PIXELS
module bg_model_reader #(
  parameter int unsigned DATA_W       = bg_model_pkg::DATA_W,
  parameter int unsigned ADDR_W       = bg_model_pkg::ADDR_W,
  parameter int unsigned FRAME_PIXELS = bg_model_pkg::FRAME_PIXELS,
  parameter int unsigned RD_LAT       = bg_model_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_de,
  input  logic              in_vsync,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_de,
  output logic              out_vsync,
  output logic [DATA_W-1:0] out_pixel,
  output logic [DATA_W-1:0] out_bg,
  output logic [ADDR_W-1:0] out_addr,
  output logic              frame_err
);

  localparam int unsigned     DlW      = 2 + DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_PIXELS - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wrap_pend_q, wrap_pend_d;
  logic              frame_err_q, frame_err_d;

  // wrap_pend: the last pixel slot of the frame was just used and no vsync has
  // followed yet; a further non-vsync pixel means the frame is too long.
  always_comb begin
    mem_rd_en   = in_de & ~rst;
    mem_addr    = in_vsync ? '0 : cnt_q;
    cnt_d       = cnt_q;
    wrap_pend_d = wrap_pend_q;
    frame_err_d = frame_err_q;
    if (in_vsync) begin
      // A pixel in the vsync cycle takes address 0, so the next one takes 1.
      cnt_d       = in_de ? ADDR_W'(1) : '0;
      wrap_pend_d = 1'b0;
    end else if (in_de) begin
      if (wrap_pend_q) frame_err_d = 1'b1;
      wrap_pend_d = (cnt_q == LastAddr);
      cnt_d       = (cnt_q == LastAddr) ? '0 : cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      wrap_pend_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      wrap_pend_q <= wrap_pend_d;
      frame_err_q <= frame_err_d;
    end
  end

  logic [DlW-1:0] dl_in, dl_out;

  assign dl_in = {in_de, in_vsync, in_pixel, mem_addr};

  bg_delay_line #(
    .W     (DlW),
    .DEPTH (RD_LAT)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign {out_de, out_vsync, out_pixel, out_addr} = dl_out;
  assign out_bg    = mem_rdata;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_bg_model_reader.sv
module tb_bg_model_reader;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 17;
  localparam int unsigned FP  = 16;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_de, in_vsync;
  logic [DW-1:0] in_pixel;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          out_de, out_vsync;
  logic [DW-1:0] out_pixel, out_bg;
  logic [AW-1:0] out_addr;
  logic          frame_err;

  always #5 clk = ~clk;

  bg_model_reader #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .FRAME_PIXELS (FP),
    .RD_LAT       (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_de     (in_de),
    .in_vsync  (in_vsync),
    .in_pixel  (in_pixel),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_de    (out_de),
    .out_vsync (out_vsync),
    .out_pixel (out_pixel),
    .out_bg    (out_bg),
    .out_addr  (out_addr),
    .frame_err (frame_err)
  );

  // Behavioural BRAM, mem[i] = i + 100, LAT-cycle read latency.
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_rd_en ? DW'(mem_addr + 100) : '0;
    for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic          vs;
    logic [DW-1:0] pix;
    logic [AW-1:0] addr;
    logic [DW-1:0] bg;
  } exp_t;
  exp_t sb[$];

  // Reference model: pixel index since the last vsync; address is that index
  // modulo the frame size, and any index past the frame end is an overflow.
  int   m_idx = 0;
  logic m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: whenever the DUT presents a pixel, pop and compare.
  always @(negedge clk) begin
    if (!rst && out_de === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_de", 32'(out_de), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_latency", 32'(cyc), 32'(e.due));
        check("out_vsync", 32'(out_vsync), 32'(e.vs));
        check("out_pixel", 32'(out_pixel), 32'(e.pix));
        check("out_addr", 32'(out_addr), 32'(e.addr));
        check("out_bg", 32'(out_bg), 32'(e.bg));
      end
    end
  end

  // One input cycle, driven just after a negedge.
  task automatic step(input logic de, input logic vs, input logic [DW-1:0] pix);
    int            idx;
    logic [AW-1:0] a;
    in_de = de; in_vsync = vs; in_pixel = pix;
    idx = vs ? 0 : m_idx;
    a   = AW'(idx % int'(FP));
    #1;
    check("mem_rd_en", 32'(mem_rd_en), 32'(de));
    if (de) begin
      exp_t e;
      check("mem_addr", 32'(mem_addr), 32'(a));
      e.due = cyc + int'(LAT); e.vs = vs; e.pix = pix; e.addr = a; e.bg = DW'(a + 100);
      sb.push_back(e);
      if (idx >= int'(FP)) m_err = 1'b1;
      m_idx = idx + 1;
    end else if (vs) begin
      m_idx = 0;
    end
    @(negedge clk);
    check("frame_err", 32'(frame_err), 32'(m_err));
  endtask

  task automatic do_reset();
    in_de = 1'b1; in_vsync = 1'b0; in_pixel = 8'h55; rst = 1'b1;
    #1;
    check("rd_en_in_rst", 32'(mem_rd_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; in_de = 1'b0;
    sb.delete();
    m_idx = 0; m_err = 1'b0;
    @(negedge clk);
    check("rst_out_de", 32'(out_de), 32'd0);
    check("rst_out_vsync", 32'(out_vsync), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_pixel", 32'(out_pixel), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_de = 1'b0; in_vsync = 1'b0; in_pixel = '0;
    @(negedge clk);
    do_reset();

    // 1: full frame
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < int'(FP); i++) step(1'b1, 1'b0, 8'(i));
    idle(3);

    // 2: vsync and de together, then the next pixel
    step(1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b0, 8'h3C);
    idle(3);

    // 3: overflow, frame_err sticky until reset
    do_reset();
    for (int i = 0; i < int'(FP) + 1; i++) step(1'b1, 1'b0, 8'(i + 7));
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(i));
    idle(3);
    do_reset();

    // 4: short frame, then a new one
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(i + 40));
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(i + 60));
    idle(3);

    // 5: gapped de
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h11);
    step(1'b0, 1'b0, 8'h22);
    step(1'b1, 1'b0, 8'h33);
    step(1'b1, 1'b0, 8'h44);
    step(1'b0, 1'b0, 8'h55);
    idle(3);

    // 6: reset mid-frame, then a fresh frame
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(i + 80));
    do_reset();
    step(1'b1, 1'b1, 8'h9E);
    step(1'b1, 1'b0, 8'h9F);
    idle(3);

    // Random traffic, including overlong frames
    for (int n = 0; n < 600; n++) begin
      logic de, vs;
      de = ($urandom_range(0, 3) != 0);
      vs = ($urandom_range(0, 22) == 0);
      step(de, vs, 8'($urandom));
      if ($urandom_range(0, 250) == 0) do_reset();
    end
    idle(LAT + 2);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
